// File: rtl/mips_cache_pkg.sv
// Shared types for the MIPS cache controller.
// Holds the write-buffer entry layout, drain FSM states and defaults.
package mips_cache_pkg;

    localparam int WB_DEPTH = 4;

    typedef enum logic [1:0] {
        WB_IDLE    = 2'd0,
        WB_PENDING = 2'd1,
        WB_WRITING = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wb_entry_t;

    // Overlay the enabled byte lanes of a new store onto an existing entry.
    function automatic wb_entry_t wb_merge(
        input wb_entry_t   old,
        input logic [31:0] data,
        input logic [3:0]  be
    );
        wb_entry_t res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res.data[8*i +: 8] = data[8*i +: 8];
            end
        end
        res.be = old.be | be;
        return res;
    endfunction

endpackage

// File: rtl/mips_cache_write_buffer.sv
// Posted-write FIFO between the CPU data port and the Avalon bus.
// Merges repeated stores into the newest entry; drains on bus grant.
module mips_cache_write_buffer
    import mips_cache_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        write_en,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    input  logic        active,
    input  logic        waitrequest,
    output logic [31:0] write_addr,
    output logic [31:0] write_data,
    output logic [3:0]  write_byteenable,
    output logic        write_writeenable,
    output logic [1:0]  state_out,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [AW-1:0]   last;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    wb_state_t       state;
    wb_state_t       state_nxt;

    logic            in_flight_tail;
    logic            merge;
    logic            enq;
    logic            pop;
    wb_entry_t       new_entry;
    wb_entry_t       merged;
    logic            unused_lsb;

    assign unused_lsb = ^addr[1:0];

    assign last  = tail - AW'(1);
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // The newest entry is only in flight when it is also the head.
    assign in_flight_tail = (state == WB_WRITING) && (count == CW'(1));

    // Classify this cycle's store and detect a completed bus write.
    always_comb begin
        merge = write_en && !empty && !in_flight_tail
             && (mem[last].addr == addr[31:2]);
        enq   = write_en && !merge && !full;
        pop   = (state == WB_WRITING) && !waitrequest;
        count_nxt = count + CW'(enq) - CW'(pop);
        new_entry = '{addr: addr[31:2], data: writedata, be: byteenable};
        merged    = wb_merge(mem[last], writedata, byteenable);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (enq) begin
                mem[tail] <= new_entry;
                tail      <= tail + AW'(1);
            end
            if (merge) begin
                mem[last] <= merged;
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            count <= count_nxt;
        end
    end

    // Drain FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Drain FSM next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            WB_IDLE: begin
                if (enq) begin
                    state_nxt = WB_PENDING;
                end
            end
            WB_PENDING: begin
                if (active) begin
                    state_nxt = WB_WRITING;
                end
            end
            WB_WRITING: begin
                if (pop) begin
                    state_nxt = (count_nxt == '0) ? WB_IDLE : WB_PENDING;
                end
            end
            default: state_nxt = WB_IDLE;
        endcase
    end

    // Bus-side outputs: head entry always visible, strobe only when writing.
    always_comb begin
        write_writeenable = (state == WB_WRITING);
        state_out         = state;
        write_addr        = '0;
        write_data        = '0;
        write_byteenable  = '0;
        if (!empty) begin
            write_addr       = {mem[head].addr, 2'b00};
            write_data       = mem[head].data;
            write_byteenable = mem[head].be;
        end
    end

endmodule

// File: tb/tb_mips_cache_write_buffer.sv
// Self-checking bench for mips_cache_write_buffer.
// Directed scenarios followed by random traffic against a queue model.
module tb_mips_cache_write_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        write_en;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        active;
    logic        waitrequest;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic [3:0]  write_byteenable;
    logic        write_writeenable;
    logic [1:0]  state_out;
    logic        full;
    logic        empty;

    mips_cache_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .addr             (addr),
        .write_en         (write_en),
        .writedata        (writedata),
        .byteenable       (byteenable),
        .active           (active),
        .waitrequest      (waitrequest),
        .write_addr       (write_addr),
        .write_data       (write_data),
        .write_byteenable (write_byteenable),
        .write_writeenable(write_writeenable),
        .state_out        (state_out),
        .full             (full),
        .empty            (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } ent_t;

    ent_t q[$];
    bit   busy;
    int   checks;
    int   failures;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Apply the buffer's rules to the inputs seen at this edge.
    task automatic model_edge();
        int   n;
        bit   do_pop;
        ent_t e;
        n = q.size();
        do_pop = busy && !waitrequest;
        if (write_en) begin
            if (n > 0 && !(busy && n == 1) && q[n-1].a == {addr[31:2], 2'b00}) begin
                e = q[n-1];
                for (int i = 0; i < 4; i++) begin
                    if (byteenable[i]) e.d[8*i +: 8] = writedata[8*i +: 8];
                end
                e.b = e.b | byteenable;
                q[n-1] = e;
            end else if (n < DEPTH) begin
                e.a = {addr[31:2], 2'b00};
                e.d = writedata;
                e.b = byteenable;
                q.push_back(e);
            end
        end
        if (do_pop) begin
            void'(q.pop_front());
            busy = 0;
        end else if (!busy && n > 0 && active) begin
            busy = 1;
        end
    endtask

    task automatic compare();
        int n;
        n = q.size();
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(n == DEPTH));
        check("state", 32'(state_out), (n == 0) ? 32'd0 : (busy ? 32'd2 : 32'd1));
        check("strobe", 32'(write_writeenable), 32'(busy));
        check("waddr", write_addr, (n == 0) ? 32'd0 : q[0].a);
        check("wdata", write_data, (n == 0) ? 32'd0 : q[0].d);
        check("wbe", 32'(write_byteenable), (n == 0) ? 32'd0 : 32'(q[0].b));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic store(logic [31:0] a, logic [31:0] d, logic [3:0] b);
        addr = a;
        writedata = d;
        byteenable = b;
        write_en = 1'b1;
        step();
        write_en = 1'b0;
    endtask

    task automatic drain(int cycles);
        active = 1'b1;
        waitrequest = 1'b0;
        repeat (cycles) step();
        active = 1'b0;
    endtask

    // Pull reset mid-cycle and confirm outputs clear without a clock edge.
    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        check("rst_strobe", 32'(write_writeenable), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_waddr", write_addr, 32'd0);
        q.delete();
        busy = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    int          hi;
    logic [31:0] seen[$];

    initial begin
        checks = 0;
        failures = 0;
        busy = 0;
        rst = 1'b0;
        addr = '0;
        write_en = 1'b0;
        writedata = '0;
        byteenable = '0;
        active = 1'b0;
        waitrequest = 1'b0;
        #12;
        compare();
        check("rst_wbe", 32'(write_byteenable), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // single store and drain
        store(32'h1004, 32'hDEADBEEF, 4'hF);
        check("s1_state", 32'(state_out), 32'd1);
        check("s1_addr", write_addr, 32'h1004);
        active = 1'b1;
        waitrequest = 1'b1;
        hi = 0;
        repeat (4) begin
            step();
            if (write_writeenable && write_data == 32'hDEADBEEF) hi++;
        end
        waitrequest = 1'b0;
        step();
        active = 1'b0;
        check("s1_hi", 32'(hi), 32'd4);
        check("s1_empty", 32'(empty), 32'd1);

        // merge a held store and a second lane
        addr = 32'h2000;
        writedata = 32'h000000AA;
        byteenable = 4'h1;
        write_en = 1'b1;
        repeat (5) step();
        writedata = 32'h0000BB00;
        byteenable = 4'h2;
        step();
        write_en = 1'b0;
        check("mg_data", write_data, 32'h0000BBAA);
        check("mg_be", 32'(write_byteenable), 32'h3);
        drain(3);

        // fill, drop fifth, drain in order
        for (int i = 0; i < 4; i++) store(32'(i * 4), 32'(i + 1), 4'hF);
        check("fill_full", 32'(full), 32'd1);
        store(32'h10, 32'h55, 4'hF);
        check("drop_head", write_addr, 32'h0);
        seen.delete();
        active = 1'b1;
        waitrequest = 1'b0;
        repeat (9) begin
            step();
            if (write_writeenable) seen.push_back(write_addr);
        end
        active = 1'b0;
        check("drain_n", 32'(seen.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            check("drain_ord", seen[i], 32'(i * 4));
        end

        // pop while full with a concurrent store
        for (int i = 0; i < 4; i++) store(32'(i * 4), 32'hA0 + 32'(i), 4'hF);
        active = 1'b1;
        waitrequest = 1'b1;
        step();
        active = 1'b0;
        waitrequest = 1'b0;
        store(32'h20, 32'h77, 4'hF);
        check("pwf_full", 32'(full), 32'd0);
        store(32'h20, 32'h77, 4'hF);
        check("pwf_full2", 32'(full), 32'd1);
        drain(10);

        // active dropped mid-transfer
        store(32'h3000, 32'h1234, 4'hF);
        active = 1'b1;
        waitrequest = 1'b1;
        step();
        active = 1'b0;
        repeat (2) step();
        check("ad_hold", 32'(write_writeenable), 32'd1);
        waitrequest = 1'b0;
        step();
        check("ad_done", 32'(state_out), 32'd0);
        store(32'h3004, 32'h1, 4'hF);
        active = 1'b1;
        waitrequest = 1'b1;
        step();
        active = 1'b0;
        repeat (2) step();
        waitrequest = 1'b0;
        store(32'h3008, 32'h2, 4'hF);
        step();
        check("ad_pend", 32'(state_out), 32'd1);
        check("ad_nostb", 32'(write_writeenable), 32'd0);
        drain(4);

        // async reset during a transfer
        store(32'h4000, 32'h9, 4'hF);
        active = 1'b1;
        waitrequest = 1'b1;
        step();
        async_reset();
        active = 1'b0;
        waitrequest = 1'b0;

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            addr = 32'h100 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
            writedata = $urandom;
            byteenable = 4'($urandom);
            write_en = ($urandom_range(0, 99) < 55);
            active = ($urandom_range(0, 99) < 40);
            waitrequest = ($urandom_range(0, 99) < 35);
            step();
            if ($urandom_range(0, 399) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_cache_write_buffer.md
# mips_cache_write_buffer

Posted-write FIFO between the MIPS data port and the Avalon memory bus, sitting beside the instruction and data caches inside the cache controller. It captures CPU stores in one cycle and drains them to memory as Avalon write transfers when the controller grants the bus. It merges repeated stores to the newest entry, so a store held across CPU stall cycles occupies one slot. It reports full/empty so the controller can stall the CPU or schedule bus writes.

## Interface
- DEPTH, 4: number of entries (power of two, ≥2).
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- addr  in  32  CPU store byte address.
- write_en  in  1  CPU store request this cycle.
- writedata  in  32  store data.
- byteenable  in  4  store byte lanes.
- active  in  1  controller grants bus to buffer.
- waitrequest  in  1  Avalon slave stall.
- write_addr  out  32  head entry word address (`[1:0]`=0); 0 when empty.
- write_data  out  32  head entry data; 0 when empty.
- write_byteenable  out  4  head entry lanes; 0 when empty.
- write_writeenable  out  1  Avalon write strobe.
- state_out  out  2  drain FSM state.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

## Operation
- Entry = {word address `addr[31:2]`, data[31:0], byteenable[3:0]}; circular head/tail pointers plus count.
- Accept, evaluated at each edge with write_en=1:
  - Merge if the tail entry exists, is not in flight, and its word address equals `addr[31:2]`: overwrite enabled byte lanes; tail byteenable |= byteenable. Merge is allowed when full. No count change.
  - Otherwise enqueue if !full (count+1).
  - Otherwise drop; the controller must hold the CPU while full.
- In flight: the head entry while state is WRITING. When count==1 the in-flight head is also the tail, so no merge into it.
- FSM, state_out encoding:
  - IDLE=0: empty. Goes to PENDING when an entry is accepted.
  - PENDING=1: non-empty, not driving. Goes to WRITING at an edge with active=1.
  - WRITING=2: write_writeenable=1, with head fields on outputs.
    - Edge with waitrequest=0: pop head; go to IDLE if now empty, else PENDING.
    - waitrequest=1: stay; outputs stable.
- Once WRITING, the transfer completes regardless of active; active is checked only in PENDING.
- write_addr/data/byteenable combinationally reflect the head in every state.
- full/empty are combinational from count.

## Timing
- Reset (rst low, async): count=0, pointers=0, state IDLE; write_writeenable=0, full=0, empty=1, state_out=0, head outputs 0.
- Enqueue latency: entry visible on empty/full/head outputs the cycle after the write_en edge.
- Strobe asserts exactly one cycle after active is first sampled high in PENDING.
- Every accepted write is followed by at least one cycle with write_writeenable=0 (PENDING) before the next write. Minimum 2 cycles per drained entry.
- Simultaneous pop and enqueue:
  - Not full: count unchanged, new entry at tail.
  - Full: enqueue refused because full is sampled before the pop. Merge is still allowed if the target is not in flight.
- Simultaneous pop and merge into in-flight head: not possible; the merge check excludes the in-flight head.

## Structure
- Shared package mips_cache_pkg:
  - wb_state_t enum (WB_IDLE=2'd0, WB_PENDING=2'd1, WB_WRITING=2'd2).
  - wb_entry_t packed struct {addr[29:0], data[31:0], be[3:0]}.
  - Default depth constant.
- Single module; storage array, pointers and FSM inline. No sub-module.

## Test plan
- **Single store and drain:**
  - Reset, then write_en with addr 0x1004, data 0xDEADBEEF, be 0xF → next cycle empty=0, state_out=1, write_addr=0x1004.
  - active=1, waitrequest=1 for 3 cycles then 0 → strobe high 4 cycles with stable fields, then empty=1, state_out=0.
- **Merge:**
  - write_en held 5 cycles at 0x2000 with be=0x1, data 0x000000AA; then be=0x2, data 0x0000BB00 → one entry.
  - Drain shows data 0x0000BBAA, be 0x3.
- **Fill:**
  - 4 stores to 0x0, 0x4, 0x8, 0xC, then full=1; a 5th to 0x10 is dropped.
  - Drain order 0x0, 0x4, 0x8, 0xC with one-cycle strobe gaps.
- **Pop while full plus new store:**
  - Full, head accepted (waitrequest=0) with write_en to 0x20 on the same edge → 0x20 not enqueued, count=3.
  - Store to 0x20 next cycle → count=4.
- **Active drop mid-transfer:**
  - WRITING with waitrequest=1; deassert active → strobe stays until waitrequest=0, then PENDING with no new strobe.
- **Async reset mid-transfer:**
  - rst low during WRITING → strobe 0 and empty=1 immediately, without waiting for a clock edge.
